// File: rtl/midi_voice_allocator.sv
// MIDI Note On/Off and All Notes Off parser driving an 8-voice pitch/level allocator.
// Define VOICE_STEAL_EN to steal voices round-robin when all 8 are busy.
module midi_voice_allocator #(
  parameter int unsigned CHANNEL = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [7:0]       midi_data_i,
  input  logic             midi_valid_i,
  output logic             midi_ready_o,
  output logic [7:0][31:0] frequencies_o,
  output logic [7:0][31:0] voice_volumes_o,
  output logic [7:0]       voice_active_o
);

  localparam int unsigned NumVoices = 8;

  typedef enum logic [1:0] {StWaitStatus, StWaitD1, StWaitD2, StApply} state_e;

  state_e     state_q, state_d;
  logic       ready_q, ready_d;
  logic [7:0] status_q, status_d;
  logic       rs_valid_q, rs_valid_d;
  logic [6:0] d1_q, d1_d, d2_q, d2_d;

  logic [NumVoices-1:0][31:0] freq_q, freq_d;
  logic [NumVoices-1:0][6:0]  vol_q, vol_d;
  logic [NumVoices-1:0][6:0]  key_q, key_d;
  logic [NumVoices-1:0]       active_q, active_d;

  logic xfer, is_rt, is_sys, is_status, one_byte, relevant;

  assign xfer      = midi_valid_i & ready_q;
  assign is_rt     = midi_data_i >= 8'hF8;
  assign is_sys    = (midi_data_i[7:4] == 4'hF) & ~midi_data_i[3];
  assign is_status = midi_data_i[7] & (midi_data_i[7:4] != 4'hF);
  assign one_byte  = (status_q[7:4] == 4'hC) || (status_q[7:4] == 4'hD);
  assign relevant  = (status_q[3:0] == CHANNEL[3:0]) &&
                     ((status_q[7:4] == 4'h8) || (status_q[7:4] == 4'h9) ||
                      (status_q[7:4] == 4'hB));

  // State and parser registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StWaitStatus;
      ready_q    <= 1'b1;
      status_q   <= '0;
      rs_valid_q <= 1'b0;
      d1_q       <= '0;
      d2_q       <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      status_q   <= status_d;
      rs_valid_q <= rs_valid_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
    end
  end

  // Next-state: realtime bytes fall through with nothing touched
  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    rs_valid_d = rs_valid_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    if (state_q == StApply) begin
      state_d = StWaitD1;
    end else if (xfer && !is_rt) begin
      if (is_sys) begin
        rs_valid_d = 1'b0;
        state_d    = StWaitStatus;
      end else if (is_status) begin
        status_d   = midi_data_i;
        rs_valid_d = 1'b1;
        state_d    = StWaitD1;
      end else if (state_q == StWaitD2) begin
        d2_d    = midi_data_i[6:0];
        state_d = relevant ? StApply : StWaitD1;
      end else if (rs_valid_q) begin
        d1_d    = midi_data_i[6:0];
        state_d = one_byte ? StWaitD1 : StWaitD2;
      end
    end
  end

  // Outputs
  always_comb begin
    ready_d        = (state_d != StApply);
    midi_ready_o   = ready_q;
    frequencies_o  = freq_q;
    voice_active_o = active_q;
    for (int j = 0; j < NumVoices; j++) begin
      voice_volumes_o[j] = {25'd0, vol_q[j]};
    end
  end

  // Key to Hz: octave by compare chain, semitone ROM, barrel shift
  logic [7:0]  kk;
  logic [3:0]  oct, semi;
  logic [13:0] base;
  logic [31:0] note_freq;

  always_comb begin
    kk  = 8'(d1_q) + 8'd4;
    oct = '0;
    for (int i = 1; i <= 10; i++) begin
      if (kk >= 8'(12 * i)) oct = 4'(i);
    end
    semi = 4'(kk - 8'(12 * oct));
    unique case (semi)
      4'd0:    base = 14'd6645;
      4'd1:    base = 14'd7040;
      4'd2:    base = 14'd7459;
      4'd3:    base = 14'd7902;
      4'd4:    base = 14'd8372;
      4'd5:    base = 14'd8870;
      4'd6:    base = 14'd9397;
      4'd7:    base = 14'd9956;
      4'd8:    base = 14'd10548;
      4'd9:    base = 14'd11175;
      4'd10:   base = 14'd11840;
      4'd11:   base = 14'd12544;
      default: base = 14'd0;
    endcase
    note_freq = 32'(base) >> (4'd10 - oct);
  end

  logic       hit_found, free_found;
  logic [2:0] hit_idx, free_idx;

  always_comb begin
    hit_found  = 1'b0;
    free_found = 1'b0;
    hit_idx    = '0;
    free_idx   = '0;
    for (int j = NumVoices - 1; j >= 0; j--) begin
      if (active_q[j] && (key_q[j] == d1_q)) begin
        hit_found = 1'b1;
        hit_idx   = 3'(j);
      end
      if (!active_q[j]) begin
        free_found = 1'b1;
        free_idx   = 3'(j);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic [2:0] steal_ptr_q, steal_ptr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) steal_ptr_q <= '0;
    else         steal_ptr_q <= steal_ptr_d;
  end
`endif

  always_comb begin
    freq_d   = freq_q;
    vol_d    = vol_q;
    key_d    = key_q;
    active_d = active_q;
`ifdef VOICE_STEAL_EN
    steal_ptr_d = steal_ptr_q;
`endif
    if (state_q == StApply) begin
      unique case (status_q[7:4])
        4'h8, 4'h9: begin
          if ((status_q[7:4] == 4'h9) && (d2_q != '0)) begin
            if (hit_found) begin
              vol_d[hit_idx] = d2_q;
            end else if (free_found) begin
              freq_d[free_idx]   = note_freq;
              vol_d[free_idx]    = d2_q;
              key_d[free_idx]    = d1_q;
              active_d[free_idx] = 1'b1;
            end
`ifdef VOICE_STEAL_EN
            else begin
              freq_d[steal_ptr_q] = note_freq;
              vol_d[steal_ptr_q]  = d2_q;
              key_d[steal_ptr_q]  = d1_q;
              steal_ptr_d         = steal_ptr_q + 3'd1;
            end
`endif
          end else if (hit_found) begin
            active_d[hit_idx] = 1'b0;
            vol_d[hit_idx]    = '0;
          end
        end
        4'hB: begin
          if (d1_q == 7'd123) begin
            active_d = '0;
            vol_d    = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      freq_q   <= {NumVoices{32'd440}};
      vol_q    <= '0;
      key_q    <= '0;
      active_q <= '0;
    end else begin
      freq_q   <= freq_d;
      vol_q    <= vol_d;
      key_q    <= key_d;
      active_q <= active_d;
    end
  end

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Randomized bench for midi_voice_allocator against a message-level voice model.
module tb_midi_voice_allocator;

  localparam int unsigned Ch = 0;
  localparam int unsigned ToneHz [12] = '{6645, 7040, 7459, 7902, 8372, 8870,
                                           9397, 9956, 10548, 11175, 11840, 12544};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       midi_data = '0;
  logic             midi_valid = 1'b0;
  logic             midi_ready;
  logic [7:0][31:0] frequencies;
  logic [7:0][31:0] voice_volumes;
  logic [7:0]       voice_active;

  midi_voice_allocator #(.CHANNEL(Ch)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .midi_data_i     (midi_data),
    .midi_valid_i    (midi_valid),
    .midi_ready_o    (midi_ready),
    .frequencies_o   (frequencies),
    .voice_volumes_o (voice_volumes),
    .voice_active_o  (voice_active)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  // Reference model state
  int unsigned m_freq [8];
  int unsigned m_vol [8];
  int unsigned m_key [8];
  logic [7:0]  m_act;
  int          m_ptr;
  bit          m_rs_valid;
  logic [7:0]  m_rs;
  logic [6:0]  m_data [$];
  logic [7:0]  p_st;
  logic [6:0]  p_k, p_v;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned key_freq(input int unsigned n);
    int unsigned k;
    k = n + 4;
    return ToneHz[k % 12] >> (10 - k / 12);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 8; j++) begin
      m_freq[j] = 440;
      m_vol[j]  = 0;
      m_key[j]  = 0;
    end
    m_act = '0;
    m_ptr = 0;
    m_rs_valid = 1'b0;
    m_rs = '0;
    m_data.delete();
  endtask

  task automatic model_apply(input logic [7:0] st, input logic [6:0] k, input logic [6:0] v);
    int hit, idle;
    hit = -1;
    idle = -1;
    for (int j = 0; j < 8; j++) begin
      if (m_act[j] && m_key[j] == k && hit < 0) hit = j;
      if (!m_act[j] && idle < 0) idle = j;
    end
    if (st[7:4] == 4'h9 && v != 0) begin
      if (hit >= 0) m_vol[hit] = v;
      else if (idle >= 0) begin
        m_freq[idle] = key_freq(k);
        m_vol[idle]  = v;
        m_key[idle]  = k;
        m_act[idle]  = 1'b1;
      end else begin
`ifdef VOICE_STEAL_EN
        m_freq[m_ptr] = key_freq(k);
        m_vol[m_ptr]  = v;
        m_key[m_ptr]  = k;
        m_ptr = (m_ptr + 1) % 8;
`endif
      end
    end else if (st[7:4] == 4'h8 || st[7:4] == 4'h9) begin
      if (hit >= 0) begin
        m_act[hit] = 1'b0;
        m_vol[hit] = 0;
      end
    end else if (st[7:4] == 4'hB && k == 7'd123) begin
      m_act = '0;
      for (int j = 0; j < 8; j++) m_vol[j] = 0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, output bit applied);
    int need;
    applied = 1'b0;
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin
      m_rs_valid = 1'b0;
      m_data.delete();
      return;
    end
    if (b[7]) begin
      m_rs = b;
      m_rs_valid = 1'b1;
      m_data.delete();
      return;
    end
    if (!m_rs_valid) return;
    m_data.push_back(b[6:0]);
    need = (m_rs[7:4] == 4'hC || m_rs[7:4] == 4'hD) ? 1 : 2;
    if (m_data.size() == need) begin
      if (need == 2 && m_rs[3:0] == 4'(Ch) &&
          (m_rs[7:4] == 4'h8 || m_rs[7:4] == 4'h9 || m_rs[7:4] == 4'hB)) begin
        applied = 1'b1;
        p_st = m_rs;
        p_k  = m_data[0];
        p_v  = m_data[1];
      end
      m_data.delete();
    end
  endtask

  task automatic compare_outputs(input string tag);
    for (int j = 0; j < 8; j++) begin
      check_eq($sformatf("%s_freq%0d", tag, j), frequencies[j], m_freq[j]);
      check_eq($sformatf("%s_vol%0d", tag, j), voice_volumes[j], m_vol[j]);
    end
    check_eq($sformatf("%s_active", tag), 32'(voice_active), 32'(m_act));
  endtask

  // Drive one byte; on an applied message check the APPLY bubble and the update timing
  task automatic send_byte(input logic [7:0] b);
    int guard;
    bit applied;
    guard = 0;
    midi_data  = b;
    midi_valid = 1'b1;
    while (midi_ready !== 1'b1 && guard < 8) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check_eq("ready_wait", 32'(guard < 8), 32'd1);
    @(posedge clk);
    #1;
    midi_valid = 1'b0;
    model_byte(b, applied);
    if (applied) begin
      check_eq("ready_in_apply", 32'(midi_ready), 32'd0);
      compare_outputs("pre_apply");
      model_apply(p_st, p_k, p_v);
      @(posedge clk);
      #1;
      check_eq("ready_after_apply", 32'(midi_ready), 32'd1);
      compare_outputs("post_apply");
    end else begin
      check_eq("ready_idle", 32'(midi_ready), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] st;
    logic [3:0] hi, chn;
    logic [6:0] k, v;
    int         ty;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_outputs("reset");
    check_eq("reset_ready", 32'(midi_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // First note: A4 on voice 0
    send_byte(8'h90); send_byte(8'h45); send_byte(8'h64);
    check_eq("t1_freq0", frequencies[0], 32'd440);
    check_eq("t1_vol0", voice_volumes[0], 32'd100);
    check_eq("t1_active", 32'(voice_active), 32'h01);

    // Running status: C4 on, A4 off
    send_byte(8'h3C); send_byte(8'h50);
    send_byte(8'h45); send_byte(8'h00);
    check_eq("t2_freq1", frequencies[1], 32'd261);
    check_eq("t2_vol1", voice_volumes[1], 32'd80);
    check_eq("t2_freq0_kept", frequencies[0], 32'd440);
    check_eq("t2_vol0", voice_volumes[0], 32'd0);
    check_eq("t2_active", 32'(voice_active), 32'h02);

    // Realtime mid-message, then a foreign channel
    send_byte(8'h90); send_byte(8'hF8); send_byte(8'h40); send_byte(8'h40);
    send_byte(8'h91); send_byte(8'h40); send_byte(8'h40);
    compare_outputs("t3");

    // All Notes Off, then an unrelated controller
    send_byte(8'hB0); send_byte(8'h7B); send_byte(8'h00);
    check_eq("t4_active", 32'(voice_active), 32'h00);
    send_byte(8'hB0); send_byte(8'h07); send_byte(8'h40);
    compare_outputs("t4_cc7");

    // Fill all voices with keys 60..67, then C5
    send_byte(8'h90);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(60 + i));
      send_byte(8'h64);
    end
    check_eq("t5_full", 32'(voice_active), 32'hFF);
    send_byte(8'h48); send_byte(8'h70);
`ifdef VOICE_STEAL_EN
    check_eq("t5_steal_freq0", frequencies[0], 32'd523);
`else
    check_eq("t5_nosteal_freq0", frequencies[0], 32'd261);
`endif
    send_byte(8'hB0); send_byte(8'h7B); send_byte(8'h00);

    // Random message mix
    for (int m = 0; m < 400; m++) begin
      ty = int'($urandom_range(0, 9));
      case (ty)
        0, 1:    hi = 4'h8;
        2, 3, 4: hi = 4'h9;
        5:       hi = 4'hB;
        6:       hi = 4'hC;
        7:       hi = 4'hE;
        8:       hi = 4'hD;
        default: hi = 4'h9;
      endcase
      chn = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'(Ch);
      st  = {hi, chn};
      k   = 7'(60 + $urandom_range(0, 11));
      if (hi == 4'hB && $urandom_range(0, 2) == 0) k = 7'd123;
      v   = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      if ($urandom_range(0, 2) != 0) send_byte(st);
      if ($urandom_range(0, 15) == 0) send_byte(8'hF8 + 8'($urandom_range(0, 7)));
      send_byte({1'b0, k});
      if ($urandom_range(0, 24) == 0) send_byte(8'hF0 + 8'($urandom_range(0, 7)));
      if (hi != 4'hC && hi != 4'hD) send_byte({1'b0, v});
      if ($urandom_range(0, 7) == 0) compare_outputs("rand_idle");
    end

    // Reset between key and velocity
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    send_byte(8'h90); send_byte(8'h3E);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_outputs("mid_reset");
    check_eq("mid_reset_ready", 32'(midi_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_byte(8'h50);
    repeat (3) @(posedge clk);
    #1;
    compare_outputs("lone_data");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
